// File: rtl/mem_stage_lsu_pkg.sv
// Shared RV32I definitions used by the MEM-stage load/store unit: access width codes,
// LSU FSM states and the exception cause encoding.
package RV32I_definitions;

  // Bits [1:0] give log2 of the access size in bytes; bit [2] selects zero extension.
  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LD  = 3'd3,
    LBU = 3'd4,
    LHU = 3'd5,
    LWU = 3'd6
  } mem_op_e;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_WAIT_G = 2'd1,
    LSU_WAIT_R = 2'd2
  } lsu_state_e;

  localparam logic [1:0] EXC_NONE           = 2'd0;
  localparam logic [1:0] EXC_LOAD_MISALIGN  = 2'd1;
  localparam logic [1:0] EXC_STORE_MISALIGN = 2'd2;
  localparam logic [1:0] EXC_BUS_ERROR      = 2'd3;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Request/grant/response data-memory bus between the LSU (master) and memory (slave).
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [NB-1:0]   mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store replication and byte enables, load extract and
// sign/zero extension, and the raw misalignment flag for the access size.
module lsu_align
  import RV32I_definitions::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  mem_op_e         op,
  input  logic [OFFW-1:0] offset,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] ld_rdata,
  output logic            misaligned,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data
);

  logic [1:0]      size;
  logic [OFFW-1:0] mask;
  logic [OFFW-1:0] lane;
  logic [XLEN-1:0] shifted;

  // NOTE: every output of an always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    // A 32-bit datapath has no doubleword; treat that code as a word access.
    size       = (NB == 4 && op[1:0] == 2'd3) ? 2'd2 : op[1:0];
    mask       = OFFW'((1 << size) - 1);
    misaligned = |(offset & mask);
    lane       = offset & ~mask;
    be         = NB'(((1 << (1 << size)) - 1) << lane);
    shifted    = ld_rdata >> {lane, 3'b000};

    // Replication places the datum in every lane of its size, so the addressed one is covered.
    unique case (size)
      2'd0:    wdata = {NB{st_data[7:0]}};
      2'd1:    wdata = {(NB/2){st_data[15:0]}};
      2'd2:    wdata = {(NB/4){st_data[31:0]}};
      default: wdata = st_data;
    endcase

    unique case (size)
      2'd0:    ld_data = op[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'd1:    ld_data = op[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'd2:    ld_data = op[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage load/store unit with grant/response bus, timeout trap and stall.
// Define MEM_STAGE_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module mem_stage_lsu
  import RV32I_definitions::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            EX_valid,
  input  logic            EX_Mem_wr_en,
  input  logic            EX_Mem_rd_en,
  input  mem_op_e         EX_Mem_op,
  input  logic            EX_MemToReg,
  input  logic            EX_RegFile_wr_en,
  input  logic [XLEN-1:0] EX_ALU_result,
  input  logic [XLEN-1:0] EX_Rs2_data,
  input  logic [4:0]      EX_Rd_addr,
  input  logic            EX_Exception,
  input  logic            ForwardM,
  input  logic [XLEN-1:0] WB_Rd_data,
  mem_stage_lsu_if.master bus,
  output logic            mem_stall,
  output logic            MEM_valid,
  output logic            MEM_MemToReg,
  output logic            MEM_RegFile_wr_en,
  output logic [XLEN-1:0] MEM_ALU_result,
  output logic [XLEN-1:0] MEM_dout,
  output logic [4:0]      MEM_Rd_addr,
  output logic            MEM_Exception,
  output logic [1:0]      MEM_Exc_cause
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_e      state, state_nxt;
  logic [7:0]      wait_cnt;
  logic [XLEN-1:0] lat_addr, lat_sdata;
  mem_op_e         lat_op;
  logic            lat_we;

  logic            access, is_idle, timed_out, ld_done;
  mem_op_e         cur_op;
  logic [XLEN-1:0] cur_addr, cur_sdata;
  logic            cur_we;
  logic            misaligned_raw, misaligned;
  logic [1:0]      cause_now;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wdata, ld_data;

  assign access    = EX_valid & (EX_Mem_wr_en | EX_Mem_rd_en) & ~EX_Exception;
  assign is_idle   = (state == LSU_IDLE);
  assign timed_out = ~is_idle & (wait_cnt == 8'(TIMEOUT - 1));

  // The request is steered from EX while idle and from the captured copy while waiting.
  assign cur_op    = is_idle ? EX_Mem_op : lat_op;
  assign cur_addr  = is_idle ? EX_ALU_result : lat_addr;
  assign cur_sdata = is_idle ? (ForwardM ? WB_Rd_data : EX_Rs2_data) : lat_sdata;
  assign cur_we    = is_idle ? EX_Mem_wr_en : lat_we;

  lsu_align #(.XLEN(XLEN)) u_align (
    .op         (cur_op),
    .offset     (cur_addr[OFFW-1:0]),
    .st_data    (cur_sdata),
    .ld_rdata   (bus.mem_rdata),
    .misaligned (misaligned_raw),
    .be         (be),
    .wdata      (wdata),
    .ld_data    (ld_data)
  );

`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
  assign misaligned = misaligned_raw;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned_raw;
  assign misaligned        = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    bus.mem_req = 1'b0;
    mem_stall   = 1'b0;
    ld_done     = 1'b0;
    cause_now   = EXC_NONE;
    unique case (state)
      LSU_IDLE: begin
        if (access) begin
          if (misaligned) begin
            cause_now = cur_we ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
          end else begin
            bus.mem_req = 1'b1;
            if (!bus.mem_gnt) begin
              state_nxt = LSU_WAIT_G;
              mem_stall = 1'b1;
            end else if (!cur_we) begin
              state_nxt = LSU_WAIT_R;
              mem_stall = 1'b1;
            end
          end
        end
      end
      LSU_WAIT_G: begin
        bus.mem_req = 1'b1;
        if (bus.mem_gnt) begin
          state_nxt = cur_we ? LSU_IDLE : LSU_WAIT_R;
          mem_stall = ~cur_we;
        end else if (timed_out) begin
          state_nxt = LSU_IDLE;
          cause_now = EXC_BUS_ERROR;
        end else begin
          mem_stall = 1'b1;
        end
      end
      LSU_WAIT_R: begin
        if (bus.mem_rvalid) begin
          state_nxt = LSU_IDLE;
          ld_done   = 1'b1;
        end else if (timed_out) begin
          state_nxt = LSU_IDLE;
          cause_now = EXC_BUS_ERROR;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_nxt = LSU_IDLE;
    endcase
    if (!Reset_n) bus.mem_req = 1'b0;
  end

  assign bus.mem_we    = bus.mem_req & cur_we;
  assign bus.mem_be    = bus.mem_req ? be : '0;
  assign bus.mem_addr  = {cur_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign bus.mem_wdata = wdata;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= LSU_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (is_idle || state_nxt != state) wait_cnt <= '0;
      else                               wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // NOTE: the captured request copy is data only, qualified by the FSM state, so it has no reset.
  always_ff @(posedge Clk) begin
    if (is_idle) begin
      lat_addr  <= EX_ALU_result;
      lat_sdata <= ForwardM ? WB_Rd_data : EX_Rs2_data;
      lat_op    <= EX_Mem_op;
      lat_we    <= EX_Mem_wr_en;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      MEM_valid         <= 1'b0;
      MEM_MemToReg      <= 1'b0;
      MEM_RegFile_wr_en <= 1'b0;
      MEM_ALU_result    <= '0;
      MEM_dout          <= '0;
      MEM_Rd_addr       <= '0;
      MEM_Exception     <= 1'b0;
      MEM_Exc_cause     <= EXC_NONE;
    end else if (mem_stall) begin
      // Bubble: nothing downstream may act on the held fields.
      MEM_valid         <= 1'b0;
      MEM_RegFile_wr_en <= 1'b0;
      MEM_Exception     <= 1'b0;
      MEM_Exc_cause     <= EXC_NONE;
    end else begin
      MEM_valid         <= EX_valid;
      MEM_MemToReg      <= EX_MemToReg;
      MEM_RegFile_wr_en <= EX_RegFile_wr_en & (cause_now == EXC_NONE);
      MEM_ALU_result    <= EX_ALU_result;
      MEM_dout          <= ld_done ? ld_data : '0;
      MEM_Rd_addr       <= EX_Rd_addr;
      MEM_Exception     <= (EX_valid & EX_Exception) | (cause_now != EXC_NONE);
      MEM_Exc_cause     <= cause_now;
    end
  end

  // A response must never accompany the grant of the same request.
  assert property (@(posedge Clk) disable iff (!Reset_n)
    !(bus.mem_req && bus.mem_gnt && bus.mem_rvalid));

endmodule
